// File: rtl/clkdiv_pkg.sv
// Shared constants, state encoding and reset-ratio helper for the multi-channel clock divider.
package clkdiv_pkg;
   localparam int DIV_W_DEF = 8;
   localparam int MIN_DIV   = 2;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   // 2^(k+1) truncated to w bits; a zero result falls back to the minimum ratio.
   function automatic int unsigned default_ratio(input int k, input int w);
      longint unsigned v;
      v = (64'd1 << (k + 1)) & ((64'd1 << w) - 64'd1);
      if (v == 64'd0) v = 64'(MIN_DIV);
      return 32'(v);
   endfunction
endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: shadow/active ratio, period counter, IDLE/RUN FSM with registered outputs.
// CLKDIV_ODD_DUTY50_EN adds a falling-edge register that trims odd ratios to 50 % duty.
module clkdiv_channel
   import clkdiv_pkg::*;
#(
   parameter int DIV_W = DIV_W_DEF,
   parameter int K     = 0
) (
   input  logic             clki,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [DIV_W-1:0] ratio,
   output logic             clko,
   output logic             tick
);
   localparam logic [DIV_W-1:0] RST_RATIO = DIV_W'(default_ratio(K, DIV_W));

   state_t           state;
   logic [DIV_W-1:0] shadow, active, cnt;
   logic [DIV_W-1:0] ld_val, next_shadow;
   logic [DIV_W:0]   half, cnt_inc;
   logic             boundary, clk_q;

   always_comb begin
      ld_val      = (ratio < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : ratio;
      next_shadow = load ? ld_val : shadow;
      half        = ({1'b0, active} + (DIV_W+1)'(1)) >> 1;
      cnt_inc     = {1'b0, cnt} + (DIV_W+1)'(1);
      boundary    = (cnt == active - DIV_W'(1));
   end

   always_ff @(posedge clki or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         shadow <= RST_RATIO;
         active <= RST_RATIO;
         cnt    <= '0;
         clk_q  <= 1'b0;
         tick   <= 1'b0;
      end else begin
         shadow <= next_shadow;
         tick   <= 1'b0;
         case (state)
            IDLE: begin
               // idle channels adopt a same-edge load so start-up uses the new ratio
               active <= next_shadow;
               cnt    <= '0;
               clk_q  <= 1'b0;
               if (en) begin
                  state <= RUN;
                  clk_q <= 1'b1;
                  tick  <= 1'b1;
               end
            end
            RUN: begin
               if (boundary) begin
                  active <= shadow;
                  cnt    <= '0;
                  if (en) begin
                     clk_q <= 1'b1;
                     tick  <= 1'b1;
                  end else begin
                     clk_q <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  cnt   <= cnt_inc[DIV_W-1:0];
                  clk_q <= (cnt_inc < half);
               end
            end
         endcase
      end
   end

`ifdef CLKDIV_ODD_DUTY50_EN
   logic neg_q;

   always_ff @(negedge clki or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= clk_q;
   end

   assign clko = active[0] ? (clk_q & neg_q) : clk_q;
`else
   assign clko = clk_q;
`endif
endmodule

// File: rtl/clock_divider_multi.sv
// CHANNELS independent programmable clock dividers sharing clki and rst_n.
// Optional CLKDIV_ODD_DUTY50_EN gives 50 % duty on odd ratios.
module clock_divider_multi
   import clkdiv_pkg::*;
#(
   parameter int CHANNELS = 3,
   parameter int DIV_W    = DIV_W_DEF
) (
   input  logic                      clki,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       en,
   input  logic [CHANNELS*DIV_W-1:0] div_ratio,
   input  logic [CHANNELS-1:0]       load,
   output logic [CHANNELS-1:0]       clko,
   output logic [CHANNELS-1:0]       tick
);
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      clkdiv_channel #(
         .DIV_W (DIV_W),
         .K     (k)
      ) u_ch (
         .clki  (clki),
         .rst_n (rst_n),
         .en    (en[k]),
         .load  (load[k]),
         .ratio (div_ratio[k*DIV_W +: DIV_W]),
         .clko  (clko[k]),
         .tick  (tick[k])
      );
   end
endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomised bench for clock_divider_multi against a period-position reference model.
module tb_clock_divider_multi;
   localparam int CH = 3;
   localparam int DW = 8;

   logic             clki, rst_n;
   logic [CH-1:0]    en, load, clko, tick;
   logic [CH*DW-1:0] div_ratio;

   int n_chk = 0, n_pass = 0;

   // reference: position within the current period and the ratios in force
   int m_s[CH], m_n[CH], m_pos[CH];
   bit m_run[CH], m_raw[CH], m_prev[CH];
   logic [CH-1:0] exp_clk, exp_tick;

   clock_divider_multi #(.CHANNELS(CH), .DIV_W(DW)) dut (
      .clki      (clki),
      .rst_n     (rst_n),
      .en        (en),
      .div_ratio (div_ratio),
      .load      (load),
      .clko      (clko),
      .tick      (tick)
   );

   initial clki = 1'b0;
   always #5 clki = ~clki;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic void model_reset();
      for (int c = 0; c < CH; c++) begin
         m_s[c] = 1 << (c + 1);
         m_n[c] = m_s[c];
         m_pos[c] = 0;
         m_run[c] = 0;
         m_raw[c] = 0;
         m_prev[c] = 0;
      end
   endfunction

   function automatic void model_step();
      int d, ns;
      for (int c = 0; c < CH; c++) begin
         m_prev[c] = m_raw[c];
         d  = int'(div_ratio[c*DW +: DW]);
         ns = load[c] ? ((d < 2) ? 2 : d) : m_s[c];
         if (!m_run[c]) begin
            m_n[c] = ns;
            if (en[c]) begin
               m_run[c] = 1;
               m_pos[c] = 0;
            end
         end else if (m_pos[c] == m_n[c] - 1) begin
            m_n[c] = m_s[c];
            m_pos[c] = 0;
            if (!en[c]) m_run[c] = 0;
         end else begin
            m_pos[c]++;
         end
         m_s[c] = ns;
         m_raw[c] = m_run[c] && (m_pos[c] < (m_n[c] + 1) / 2);
      end
   endfunction

   function automatic void model_outputs();
      for (int c = 0; c < CH; c++) begin
         exp_tick[c] = m_run[c] && (m_pos[c] == 0);
`ifdef CLKDIV_ODD_DUTY50_EN
         exp_clk[c] = (m_n[c] % 2 == 1) ? (m_raw[c] && m_prev[c]) : m_raw[c];
`else
         exp_clk[c] = m_raw[c];
`endif
      end
   endfunction

   task automatic cycle();
      @(posedge clki);
      #1;
      if (!rst_n) model_reset();
      else        model_step();
      model_outputs();
      chk("clko", 32'(clko), 32'(exp_clk));
      chk("tick", 32'(tick), 32'(exp_tick));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         cycle();
         load = '0;
      end
   endtask

   task automatic load_ch(input int c, input int v);
      load[c] = 1'b1;
      div_ratio[c*DW +: DW] = DW'(v);
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0;
      en = '1;
      load = '0;
      div_ratio = '0;
      model_reset();
      #1;
      chk("reset_clko", 32'(clko), 0);
      chk("reset_tick", 32'(tick), 0);
      run(3);
      rst_n = 1'b1;
      run(24);

      // odd ratio on channel 0
      load_ch(0, 5);
      run(25);

      // reload channel 1 mid-period
      load_ch(1, 6);
      run(2);
      load_ch(1, 7);
      run(1);
      load_ch(1, 6);
      run(20);

      // enable drop and restore on channel 2
      en[2] = 1'b0;
      run(14);
      en[2] = 1'b1;
      run(12);

      // clamp: idle channel 0, then load 0 together with enable
      en[0] = 1'b0;
      run(8);
      en[0] = 1'b1;
      load_ch(0, 0);
      run(6);
      load_ch(0, 1);
      run(10);

      // async reset while channel 2 is high
      load_ch(1, 9);
      load_ch(2, 3);
      run(20);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         cycle();
         load = '0;
         if (clko[2]) seen = 1;
      end
      chk("wait_clko2_high", 32'(seen), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_clko", 32'(clko), 0);
      chk("async_tick", 32'(tick), 0);
      run(2);
      rst_n = 1'b1;
      run(20);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < CH; c++) begin
            en[c] = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 9) == 0) begin
               load[c] = 1'b1;
               div_ratio[c*DW +: DW] = ($urandom_range(0, 9) == 0) ?
                  DW'($urandom_range(0, 1)) : DW'($urandom_range(2, 20));
            end
         end
         cycle();
         load = '0;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
